micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter CW, default 32: control-word width.
REQ-002 Parameter CAR_W, default 8: control-address width; control store depth 2^CAR_W.
REQ-003 Parameter OPC_W, default 8: opcode width; CAR_W >= OPC_W is required.
REQ-004 Parameter STACK_DEPTH, default 4: micro-return-stack entries, >= 1.
REQ-005 Parameter MAP_BASE, default 8'h40: base address for opcode dispatch.
REQ-006 Microword width MW = CW+CAR_W+3; fields: [MW-1:MW-3] mode, [CW+CAR_W-1:CW] next_addr, [CW-1:0] ctrl.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 data_from_ir  in  OPC_W  opcode from instruction register.
REQ-010 ir_valid  in  1  opcode on data_from_ir is valid.
REQ-011 ir_ready  out  1  sequencer accepts opcode this cycle.
REQ-012 zero_flag, carry_flag  in  1 each  datapath condition flags.
REQ-013 stall  in  1  freeze sequencer this cycle.
REQ-014 start  in  1  restart from address 0 while halted.
REQ-015 cs_we  in  1  control-store write enable.
REQ-016 cs_waddr  in  CAR_W  write address; cs_wdata  in  MW  write data.
REQ-017 control_signal  out  CW  registered control word.
REQ-018 car_addr  out  CAR_W  current control address register (CAR).
REQ-019 halted  out  1  sequencer halted; stk_err  out  1  sticky stack error.

Function
REQ-020 Microword mw = store[CAR], combinational read; store is not reset.
REQ-021 cs_we writes store[cs_waddr] at the edge; same-cycle read of that address returns the old word.
REQ-022 Advance cycle = !stall && !halted && !(mode==MAP && !ir_valid); only advance cycles update CAR and stack.
REQ-023 On advance: control_signal <= mw.ctrl; otherwise control_signal <= 0 (bubble).
REQ-024 Latency: ctrl of word at address A appears on control_signal one cycle after the advance cycle with CAR==A.
REQ-025 Mode 0 INC: CAR <= CAR+1, wrapping 2^CAR_W-1 -> 0.
REQ-026 Mode 1 JMP: CAR <= next_addr.
REQ-027 Mode 2 MAP: CAR <= (MAP_BASE + zero-extended opcode) mod 2^CAR_W; opcode consumed when ir_valid && ir_ready.
REQ-028 ir_ready = (mode==MAP) && !stall && !halted, combinational; 0 in every other mode.
REQ-029 Mode 3 JZ: CAR <= zero_flag ? next_addr : CAR+1; mode 4 JC: same using carry_flag.
REQ-030 Mode 5 CALL: push CAR+1 (wrapped), CAR <= next_addr; if stack full: no push, jump still taken, stk_err <= 1.
REQ-031 Mode 6 RET: CAR <= popped address; if stack empty: CAR <= 0, stk_err <= 1.
REQ-032 Mode 7 HALT: on advance, ctrl issued, CAR holds, halted <= 1.
REQ-033 While halted: CAR, stack held, control_signal 0; start=1 -> CAR <= 0, halted <= 0; start ignored when not halted.
REQ-034 stall=1 has priority over start and all modes; cs_we is honoured during stall and halt.
REQ-035 stk_err clears only on reset.

Reset
REQ-036 rst=0 immediately forces CAR=0, control_signal=0, halted=0, stk_err=0, stack empty; ir_ready then follows store[0].
REQ-037 Reset mid-CALL/RET/MAP discards the operation; first advance after release executes store[0].

Verification
REQ-038 Load store[0]=INC ctrl 32'h1, store[1]=JMP->0 ctrl 32'h2; release reset -> control_signal 0,1,2,1,2..., car_addr 0,1,0,1.
REQ-039 store[0]=MAP, ir_valid=0 for 3 cycles then opcode 8'h05 -> ir_ready=1, CAR held at 0 with control 0, then CAR=8'h45.
REQ-040 CALL 0->8'h10, store[8'h10]=RET -> car_addr 0,8'h10,1; five nested CALLs (depth 4) -> stk_err=1 on fifth, jump still taken.
REQ-041 JZ next_addr 8'h20 at 3: zero_flag=1 -> CAR 8'h20; zero_flag=0 -> CAR 4; INC at 8'hFF -> CAR 0.
REQ-042 HALT at 2 -> halted=1, control 0, CAR=2 held; stall+start same cycle ignored; start alone -> CAR=0, halted=0.
REQ-043 rst=0 asserted during RET with stk_err=1 -> all outputs 0 asynchronously, stack empty after release.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogrammed control sequencer: writable control store, CAR sequencing with
// branch/dispatch/call/return modes, a bounded micro-return stack and halt/restart.
module micro_sequencer #(
  parameter int                 CW          = 32,
  parameter int                 CAR_W       = 8,
  parameter int                 OPC_W       = 8,
  parameter int                 STACK_DEPTH = 4,
  parameter logic [CAR_W-1:0]   MAP_BASE    = CAR_W'('h40)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OPC_W-1:0]          data_from_ir,
  input  logic                      ir_valid,
  output logic                      ir_ready,
  input  logic                      zero_flag,
  input  logic                      carry_flag,
  input  logic                      stall,
  input  logic                      start,
  input  logic                      cs_we,
  input  logic [CAR_W-1:0]          cs_waddr,
  input  logic [CW+CAR_W+2:0]       cs_wdata,
  output logic [CW-1:0]             control_signal,
  output logic [CAR_W-1:0]          car_addr,
  output logic                      halted,
  output logic                      stk_err
);

  localparam int MW    = CW + CAR_W + 3;
  localparam int DEPTH = 2 ** CAR_W;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    M_INC  = 3'd0,
    M_JMP  = 3'd1,
    M_MAP  = 3'd2,
    M_JZ   = 3'd3,
    M_JC   = 3'd4,
    M_CALL = 3'd5,
    M_RET  = 3'd6,
    M_HALT = 3'd7
  } mode_e;

  logic [MW-1:0]    store [DEPTH];
  logic [CAR_W-1:0] stack [STACK_DEPTH];

  logic [CAR_W-1:0] car, car_nxt;
  logic [SP_W-1:0]  sp, sp_nxt;
  logic             halted_nxt, err_set, push;
  logic [CW-1:0]    ctrl_nxt;

  logic [MW-1:0]    mw;
  mode_e            mode;
  logic [CAR_W-1:0] next_addr, car_inc, map_addr;
  logic [CW-1:0]    ctrl_field;
  logic             advance, stack_full, stack_empty;
  logic [IDX_W-1:0] push_idx, pop_idx;

  assign mw         = store[car];
  assign mode       = mode_e'(mw[MW-1 -: 3]);
  assign next_addr  = mw[CW +: CAR_W];
  assign ctrl_field = mw[CW-1:0];
  assign car_inc    = car + CAR_W'(1);
  assign map_addr   = MAP_BASE + CAR_W'(data_from_ir);

  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign push_idx    = IDX_W'(sp);
  assign pop_idx     = IDX_W'(sp - SP_W'(1));

  // A MAP word waits for a valid opcode; the handshake is the advance itself.
  assign ir_ready = (mode == M_MAP) && !stall && !halted;
  assign advance  = !stall && !halted && !((mode == M_MAP) && !ir_valid);

  assign car_addr = car;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    car_nxt    = car;
    sp_nxt     = sp;
    halted_nxt = halted;
    err_set    = 1'b0;
    push       = 1'b0;
    ctrl_nxt   = '0;

    if (!stall && halted && start) begin
      car_nxt    = '0;
      halted_nxt = 1'b0;
    end

    if (advance) begin
      ctrl_nxt = ctrl_field;
      case (mode)
        M_INC:  car_nxt = car_inc;
        M_JMP:  car_nxt = next_addr;
        M_MAP:  car_nxt = map_addr;
        M_JZ:   car_nxt = zero_flag  ? next_addr : car_inc;
        M_JC:   car_nxt = carry_flag ? next_addr : car_inc;
        M_CALL: begin
          car_nxt = next_addr;
          if (stack_full) begin
            err_set = 1'b1;
          end else begin
            push   = 1'b1;
            sp_nxt = sp + SP_W'(1);
          end
        end
        M_RET: begin
          if (stack_empty) begin
            car_nxt = '0;
            err_set = 1'b1;
          end else begin
            car_nxt = stack[pop_idx];
            sp_nxt  = sp - SP_W'(1);
          end
        end
        M_HALT: halted_nxt = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      car            <= '0;
      sp             <= '0;
      halted         <= 1'b0;
      stk_err        <= 1'b0;
      control_signal <= '0;
    end else begin
      car            <= car_nxt;
      sp             <= sp_nxt;
      halted         <= halted_nxt;
      stk_err        <= stk_err | err_set;
      control_signal <= ctrl_nxt;
    end
  end

  // NOTE: storage arrays are deliberately not reset; the stack is emptied by clearing sp alone.
  always_ff @(posedge clk) begin
    if (cs_we) store[cs_waddr] <= cs_wdata;
    if (push)  stack[push_idx] <= car_inc;
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios plus randomized
// programs, all compared cycle by cycle against a queue-based reference model.
module tb_micro_sequencer;

  localparam int CW    = 32;
  localparam int CAR_W = 8;
  localparam int OPC_W = 8;
  localparam int MW    = CW + CAR_W + 3;
  localparam int MAP_B = 'h40;
  localparam int SDEP  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [OPC_W-1:0] data_from_ir = '0;
  logic             ir_valid = 1'b0;
  logic             ir_ready;
  logic             zero_flag = 1'b0;
  logic             carry_flag = 1'b0;
  logic             stall = 1'b0;
  logic             start = 1'b0;
  logic             cs_we = 1'b0;
  logic [CAR_W-1:0] cs_waddr = '0;
  logic [MW-1:0]    cs_wdata = '0;
  logic [CW-1:0]    control_signal;
  logic [CAR_W-1:0] car_addr;
  logic             halted;
  logic             stk_err;

  micro_sequencer dut (
    .clk(clk), .rst(rst), .data_from_ir(data_from_ir), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .stall(stall), .start(start), .cs_we(cs_we), .cs_waddr(cs_waddr),
    .cs_wdata(cs_wdata), .control_signal(control_signal), .car_addr(car_addr),
    .halted(halted), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [MW-1:0] m_store [256];
  int            m_car;
  logic [31:0]   m_ctrl;
  bit            m_halt, m_err;
  int            m_stk [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] uw(input int mode, input int na, input logic [31:0] ctrl);
    return {3'(mode), 8'(na), ctrl};
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, " car"},    64'(car_addr),       64'(m_car));
    check({tag, " ctrl"},   64'(control_signal), 64'(m_ctrl));
    check({tag, " halted"}, 64'(halted),         64'(m_halt));
    check({tag, " stk_err"},64'(stk_err),        64'(m_err));
  endtask

  // Assert reset mid-cycle and verify the asynchronous clear.
  task automatic do_reset(input string tag);
    stall = 1'b0; start = 1'b0; ir_valid = 1'b0; cs_we = 1'b0;
    rst = 1'b0;
    #1;
    m_car = 0; m_ctrl = '0; m_halt = 1'b0; m_err = 1'b0; m_stk.delete();
    check_outputs(tag);
  endtask

  task automatic load(input int addr, input logic [MW-1:0] w);
    cs_we = 1'b1; cs_waddr = 8'(addr); cs_wdata = w;
    @(posedge clk); #1;
    cs_we = 1'b0;
    m_store[addr] = w;
  endtask

  // One clock: predict from the spec rules, clock the DUT, compare.
  task automatic step(input string tag);
    logic [MW-1:0] w;
    int md, na, n_car;
    bit adv, exp_rdy, n_halt, n_err;
    logic [31:0] n_ctrl;
    #1;
    w  = m_store[m_car];
    md = int'(w[42:40]);
    na = int'(w[39:32]);
    exp_rdy = (md == 2) && !stall && !m_halt;
    check({tag, " ir_ready"}, 64'(ir_ready), 64'(exp_rdy));
    adv    = !stall && !m_halt && !(md == 2 && !ir_valid);
    n_car  = m_car; n_halt = m_halt; n_err = m_err;
    n_ctrl = adv ? w[31:0] : 32'h0;
    if (!stall && m_halt && start) begin n_car = 0; n_halt = 1'b0; end
    if (adv) begin
      case (md)
        0: n_car = (m_car + 1) % 256;
        1: n_car = na;
        2: n_car = (MAP_B + int'(data_from_ir)) % 256;
        3: n_car = zero_flag  ? na : (m_car + 1) % 256;
        4: n_car = carry_flag ? na : (m_car + 1) % 256;
        5: begin
          if (m_stk.size() < SDEP) m_stk.push_back((m_car + 1) % 256);
          else n_err = 1'b1;
          n_car = na;
        end
        6: begin
          if (m_stk.size() == 0) begin n_car = 0; n_err = 1'b1; end
          else n_car = m_stk.pop_back();
        end
        default: n_halt = 1'b1;
      endcase
    end
    if (cs_we) m_store[int'(cs_waddr)] = cs_wdata;
    @(posedge clk); #1;
    m_car = n_car; m_halt = n_halt; m_err = n_err; m_ctrl = n_ctrl;
    check_outputs(tag);
  endtask

  initial begin
    #2;
    do_reset("por");

    // INC/JMP loop
    load(0, uw(0, 0, 32'h1));
    load(1, uw(1, 0, 32'h2));
    rst = 1'b1;
    step("loop1"); check("loop1 car_k", 64'(car_addr), 64'h1); check("loop1 ctrl_k", 64'(control_signal), 64'h1);
    step("loop2"); check("loop2 car_k", 64'(car_addr), 64'h0); check("loop2 ctrl_k", 64'(control_signal), 64'h2);
    step("loop3"); check("loop3 ctrl_k", 64'(control_signal), 64'h1);

    // Opcode dispatch with ir_valid held low for three cycles
    do_reset("rst_map");
    load(0, uw(2, 0, 32'h33));
    load('h45, uw(7, 0, 32'h45));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("map_wait");
      check("map_wait rdy_k", 64'(ir_ready), 64'h1);
      check("map_wait car_k", 64'(car_addr), 64'h0);
    end
    ir_valid = 1'b1; data_from_ir = 8'h05;
    step("map_go");
    ir_valid = 1'b0;
    check("map_go car_k", 64'(car_addr), 64'h45);
    check("map_go ctrl_k", 64'(control_signal), 64'h33);

    // CALL / RET and stack overflow
    do_reset("rst_call");
    load(0, uw(5, 'h10, 32'h5));
    load('h10, uw(6, 0, 32'h6));
    load(1, uw(7, 0, 32'h7));
    rst = 1'b1;
    step("call");  check("call car_k", 64'(car_addr), 64'h10);
    step("ret");   check("ret car_k", 64'(car_addr), 64'h1);
    step("halt1"); check("halt1 halted_k", 64'(halted), 64'h1);

    do_reset("rst_nest");
    for (int a = 'h10; a < 'h14; a++) load(a, uw(5, a + 1, 32'(a)));
    load('h14, uw(6, 0, 32'h99));
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step("nest");
    check("nest4 err_k", 64'(stk_err), 64'h0);
    step("nest5");
    check("nest5 err_k", 64'(stk_err), 64'h1);
    check("nest5 car_k", 64'(car_addr), 64'h14);
    // Reset while the RET word is current
    do_reset("rst_in_ret");
    check("rst_in_ret rdy_k", 64'(ir_ready), 64'h0);
    load(0, uw(6, 0, 32'hA));
    rst = 1'b1;
    step("ret_empty");
    check("ret_empty err_k", 64'(stk_err), 64'h1);
    check("ret_empty car_k", 64'(car_addr), 64'h0);

    // Conditional branch and address wrap
    do_reset("rst_jz");
    load(0, uw(1, 3, 32'h10));
    load(3, uw(3, 'h20, 32'h11));
    load('h20, uw(1, 0, 32'h12));
    load(4, uw(1, 'hFF, 32'h14));
    load('hFF, uw(0, 0, 32'h13));
    rst = 1'b1;
    zero_flag = 1'b1;
    step("jz_a"); step("jz_t");
    check("jz_t car_k", 64'(car_addr), 64'h20);
    step("jz_b");
    zero_flag = 1'b0;
    step("jz_c"); step("jz_n");
    check("jz_n car_k", 64'(car_addr), 64'h4);
    step("jz_ff"); step("wrap");
    check("wrap car_k", 64'(car_addr), 64'h0);

    // Halt, stall priority over start, restart
    do_reset("rst_halt");
    load(0, uw(0, 0, 32'h1));
    load(1, uw(0, 0, 32'h2));
    load(2, uw(7, 0, 32'h7));
    rst = 1'b1;
    step("h1"); step("h2"); step("h3");
    check("h3 halted_k", 64'(halted), 64'h1);
    check("h3 ctrl_k", 64'(control_signal), 64'h7);
    check("h3 car_k", 64'(car_addr), 64'h2);
    step("h4");
    check("h4 ctrl_k", 64'(control_signal), 64'h0);
    stall = 1'b1; start = 1'b1;
    cs_we = 1'b1; cs_waddr = 8'h01; cs_wdata = uw(1, 'h30, 32'h77);
    step("h_stall");
    cs_we = 1'b0;
    check("h_stall halted_k", 64'(halted), 64'h1);
    stall = 1'b0;
    step("h_start");
    check("h_start car_k", 64'(car_addr), 64'h0);
    check("h_start halted_k", 64'(halted), 64'h0);
    start = 1'b0;
    step("h_run");
    start = 1'b1;
    step("h_ign");
    start = 1'b0;
    check("h_ign car_k", 64'(car_addr), 64'h30);
    check("h_ign ctrl_k", 64'(control_signal), 64'h77);

    // Randomized programs and stimulus
    do_reset("rst_rand");
    for (int a = 0; a < 256; a++)
      load(a, {3'($urandom_range(0, 7)), 8'($urandom), 32'($urandom)});
    rst = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) begin
        do_reset("rand_rst");
        rst = 1'b1;
      end
      stall        = ($urandom_range(0, 9) == 0);
      start        = ($urandom_range(0, 2) == 0);
      ir_valid     = 1'($urandom_range(0, 1));
      data_from_ir = 8'($urandom);
      zero_flag    = 1'($urandom_range(0, 1));
      carry_flag   = 1'($urandom_range(0, 1));
      cs_we        = ($urandom_range(0, 15) == 0);
      cs_waddr     = 8'($urandom);
      cs_wdata     = {3'($urandom_range(0, 7)), 8'($urandom), 32'($urandom)};
      step("rand");
    end
    cs_we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
